// File: rtl/compression_pkg.sv
// Shared widths, packer state type and the round/saturate helper for the
// compression chain (also used by the standalone requantizer stage).
package compression_pkg;

  localparam int DATA_WIDTH       = 26;
  localparam int REQUANTIZED_BITS = 8;
  localparam int WORD_BITS        = 32;

  typedef enum logic {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } pack_state_e;

  // Round-half-up then saturate to a signed rb-bit range. The 64-bit working
  // width covers the data_width+1 headroom needed so that adding the rounding
  // constant at positive full scale cannot wrap.
  function automatic logic signed [63:0] requant(
    input  logic signed [63:0] x,
    input  int                 shift,
    input  int                 rb,
    output logic               clip
  );
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (rb - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (rb - 1));
    clip  = 1'b0;
    if (r > max_v) begin
      r    = max_v;
      clip = 1'b1;
    end else if (r < min_v) begin
      r    = min_v;
      clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with push/pop/full/empty.
// A push while full is only taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o = (count == '0);
    full_o  = (count == (AW+1)'(Depth));
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    // Gate the read port so the output shows zero whenever nothing is buffered.
    data_o  = empty_o ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/iq_requant_packer.sv
// Requantizes decimated I/Q pairs, packs them little-endian into words and
// buffers the words in a FWFT FIFO behind a valid/ready output.
module iq_requant_packer
  import compression_pkg::*;
#(
  parameter int Data_width       = DATA_WIDTH,
  parameter int Requantized_bits = REQUANTIZED_BITS,
  parameter int Shift            = 12,
  parameter int Word_bits        = WORD_BITS,
  parameter int Fifo_depth       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Data_width-1:0] I_data_i,
  input  logic [Data_width-1:0] Q_data_i,
  input  logic                  data_valid_i,
  input  logic                  last_i,
  output logic [Word_bits-1:0]  word_o,
  output logic                  word_last_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  clip_o,
  output logic                  overflow_o
);

  // Output handshake: a word transfers on a rising clk_i edge where
  // word_valid_o && word_ready_i; word_o/word_last_o hold while valid and not ready.

  localparam int Rb = Requantized_bits;
  localparam int P  = Word_bits / (2 * Rb);
  localparam int KW = (P > 1) ? $clog2(P) : 1;

  logic [Rb-1:0]        i_rq, q_rq;
  logic                 i_clip, q_clip;
  logic                 s1_valid, s1_last;
  logic [Rb-1:0]        s1_i, s1_q;
  pack_state_e          state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [Word_bits-1:0] asm_q, word_next;
  logic                 completing;
  logic                 cmp_valid, cmp_last;
  logic [Word_bits-1:0] cmp_word;
  logic [Word_bits:0]   fifo_dout;
  logic                 fifo_full, fifo_empty;

  always_comb begin
    i_rq = Rb'(requant(64'($signed(I_data_i)), Shift, Rb, i_clip));
    q_rq = Rb'(requant(64'($signed(Q_data_i)), Shift, Rb, q_clip));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
      clip_o   <= 1'b0;
    end else begin
      s1_valid <= data_valid_i;
      s1_last  <= data_valid_i & last_i;
      s1_i     <= i_rq;
      s1_q     <= q_rq;
      clip_o   <= data_valid_i & (i_clip | q_clip);
    end
  end

  // In EMPTY the assembly register is known clear, so start from zero.
  always_comb begin
    word_next = (state_q == EMPTY) ? '0 : asm_q;
    for (int s = 0; s < P; s++) begin
      if (k_q == KW'(s)) begin
        word_next[2*s*Rb +: Rb]     = s1_i;
        word_next[(2*s+1)*Rb +: Rb] = s1_q;
      end
    end
    completing = s1_valid && (s1_last || (k_q == KW'(P - 1)));
    state_d    = state_q;
    if (s1_valid) begin
      state_d = completing ? EMPTY : FILLING;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= EMPTY;
      k_q       <= '0;
      asm_q     <= '0;
      cmp_valid <= 1'b0;
      cmp_last  <= 1'b0;
      cmp_word  <= '0;
    end else begin
      state_q   <= state_d;
      cmp_valid <= completing;
      if (s1_valid) begin
        if (completing) begin
          asm_q    <= '0;
          k_q      <= '0;
          cmp_word <= word_next;
          cmp_last <= s1_last;
        end else begin
          asm_q <= word_next;
          k_q   <= k_q + KW'(1);
        end
      end
    end
  end

  sync_fifo #(
    .Depth (Fifo_depth),
    .Width (Word_bits + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmp_valid),
    .data_i  ({cmp_last, cmp_word}),
    .pop_i   (word_ready_i),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    word_o       = fifo_dout[Word_bits-1:0];
    word_last_o  = fifo_dout[Word_bits];
    word_valid_o = !fifo_empty;
  end

  // A full FIFO is never empty, so a pop that cycle is just word_ready_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (cmp_valid && fifo_full && !word_ready_i) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: doc/iq_requant_packer.md
# iq_requant_packer

Downstream stage of the compression chain. It takes decimated I/Q sample pairs from the per-channel compression datapath and requantizes each sample from `Data_width` to `Requantized_bits`, using round-half-up and saturation. It packs the requantized pairs little-endian into `Word_bits` output words and buffers them in a small FIFO behind a valid/ready interface towards the readout/transfer logic. It also flags clipping and FIFO overflow.

## Interface
Parameters:
- `Data_width`, 26, signed input sample width (two's complement).
- `Requantized_bits`, 8, signed output sample width.
- `Shift`, 12, right-shift applied before rounding/saturation; 1 ≤ `Shift` < `Data_width`.
- `Word_bits`, 32, packed word width; must be a multiple of 2·`Requantized_bits`.
- `Fifo_depth`, 8, output FIFO depth in words; power of two, ≥ 2.

Ports:
- `clk_i`, in, 1, single clock.
- `rst_ni`, in, 1, reset; synchronous, active-low.
- `I_data_i`, in, `Data_width`, decimated I sample.
- `Q_data_i`, in, `Data_width`, decimated Q sample.
- `data_valid_i`, in, 1, pair valid. No backpressure upstream; every valid pair is accepted.
- `last_i`, in, 1, end of channel frame; qualified by `data_valid_i`.
- `word_o`, out, `Word_bits`, packed word.
- `word_last_o`, out, 1, word carries the last pair of a frame.
- `word_valid_o`, out, 1, `word_o` valid.
- `word_ready_i`, in, 1, consumer accepts the word.
- `clip_o`, out, 1, one-cycle pulse: I or Q of a pair saturated.
- `overflow_o`, out, 1, sticky: a word was dropped because the FIFO was full.

## Operation
- **Stage 1 (requantize).** Registered. Applies to I and Q independently.
  - Sign-extend to `Data_width`+1 bits.
  - Add 2^(`Shift`−1).
  - Arithmetic shift right by `Shift`.
  - Saturate to [−2^(`Requantized_bits`−1), 2^(`Requantized_bits`−1)−1].
  - `clip_o` is registered alongside, high when either sample clipped.
- **Stage 2 (pack).**
  - P = `Word_bits`/(2·`Requantized_bits`) pairs per word.
  - Slot counter k runs 0..P−1.
  - Pair k places I at bits [2k·Rb +: Rb] and Q at bits [(2k+1)·Rb +: Rb], where Rb = `Requantized_bits`.
- **Word completion.** A word completes when k = P−1, or when the pair carries `last_i` (flush).
  - Unfilled slots are zero.
  - On completion the word is pushed to the FIFO together with `word_last_o`.
  - k then returns to 0 and the assembly register clears.
- `last_i` without `data_valid_i` is ignored.
- **Packer states:**
  - EMPTY (k = 0) → FILLING on a valid non-completing pair.
  - FILLING → EMPTY on a completing pair.
- **FIFO.** First-word-fall-through; `word_valid_o` = FIFO not empty. A pop occurs when `word_valid_o` & `word_ready_i`.
- **Full FIFO, push without simultaneous pop.** The word is dropped, `overflow_o` is set, and the packer continues with the next word.
- **Full FIFO, push with simultaneous pop.** Both happen; no drop.
- **Empty FIFO.** `word_ready_i` has no effect.
- **Arithmetic.** Signed throughout; the `Data_width`+1 intermediate prevents rounding-add overflow at the positive full scale.

## Timing
- **Reset values.** On reset, all outputs are 0: `word_o`, `word_last_o`, `word_valid_o`, `clip_o`, `overflow_o`. The FIFO empties, k = 0, and the pipeline valids clear.
- **Reset mid-operation.** The partial word and all buffered words are discarded. Output is accepted again from the first valid pair after `rst_ni` returns high.
- **Latency.**
  - Edge 0: the completing pair is sampled.
  - Edge 1: stage 1 registered, `clip_o` visible.
  - Edge 2: FIFO write.
  - `word_valid_o` is high in the cycle after edge 2 if the FIFO was empty.
- **Throughput.** One pair per cycle sustained; one word per cycle drained.
- **Output stability.** `word_o` and `word_last_o` stay stable while `word_valid_o` is high and `word_ready_i` is low.
- **Overflow.** `overflow_o` rises in the cycle after the dropping edge and clears only on reset.

## Structure
- **Package `compression_pkg`:**
  - default widths (`Data_width`, `Requantized_bits`, `Word_bits`);
  - `pack_state_e` enum {EMPTY, FILLING};
  - a `requant` function (round/saturate) shared with the standalone requantizer stage.
- **Sub-module `sync_fifo`:** parameters depth and width; FWFT; push/pop/full/empty; synchronous active-low reset. It is reused by the 32-channel readout.
- Top-level RTL holds stage 1, the packer, and the flag logic.

## Test plan
Defaults throughout: `Shift`=12, Rb=8, `Word_bits`=32.
- **Rounding.** Pairs (I, Q) = (4096, −4096) then (2048, 2047) → `word_o` = 0x0001FF01, `word_last_o` = 0, valid 2 cycles after the second pair's edge. 4096→1, −4096→−1, 2048→1, 2047→0.
- **Saturation.** Pair (2^25−1, −2^25), then (0, 0) → word 0x0000807F, with a `clip_o` pulse on the first pair only.
- **Flush.** A single pair (8192, 12288) with `last_i`=1 → word 0x00000302, `word_last_o`=1. The next pair starts in slot 0.
- **Backpressure/overflow.** Hold `word_ready_i`=0 and stream 20 pairs → the first 8 words are kept, words 9–10 are dropped, and `overflow_o`=1. Releasing ready drains exactly 8 words in order.
- **Full with simultaneous push and pop.** FIFO full, `word_ready_i`=1 in the same cycle as a push → no drop, `overflow_o` stays 0, and the count is unchanged.
- **Reset mid-word.** After 1 pair, assert `rst_ni`=0 for 1 cycle → all outputs 0. The next 2 pairs form a fresh word containing no stale slot.
